dm_copy_engine: RTL and testbench
=================================

Name: dm_copy_engine

Overview:
- Initiator-side master for the 32x32 data memory: copies a block of words from a source region to a destination region of that memory.
- Drives the memory's address, write-enable and write-data ports and samples its combinational read data.
- Sits beside the datapath. The top level muxes memory ownership to this engine while busy is high.

Parameters:
- AW, 5, memory address width (word index); memory depth is 2**AW.
- DW, 32, data word width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- src  in  AW  first source word index.
- dst  in  AW  first destination word index.
- len  in  AW+1  word count, legal range 0..2**AW.
- fill_mode  in  1  selects fill instead of copy; used only with DM_FILL_EN.
- fill_data  in  DW  fill pattern; used only with DM_FILL_EN.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse when a transfer ends.
- err  out  1  valid with done; high means the request was rejected.
- dm_addr  out  AW  memory address.
- dm_we  out  1  memory write enable.
- dm_wd  out  DW  memory write data.
- dm_rd  in  DW  memory read data, combinational from dm_addr.

Behaviour:
- Reset (async, rst_n=0) forces:
  - state=IDLE;
  - busy=0, done=0, err=0, dm_we=0, dm_addr=0, dm_wd=0;
  - internal counter and word buffer cleared.
- Reset mid-transfer aborts immediately. No further writes occur; words already written stay written.
- States: IDLE, RD, WR, FIN.
- IDLE:
  - dm_we=0.
  - On start with 1<=len<=2**AW: latch src/dst/len, cnt=0, go to RD, busy=1.
  - On start with len==0: go to FIN with err=0, no memory access.
  - On start with len>2**AW: go to FIN with err=1, no memory access.
- RD:
  - dm_addr=src+cnt, dm_we=0.
  - Capture dm_rd into buf at the clock edge, then go to WR.
- WR:
  - dm_addr=dst+cnt, dm_we=1, dm_wd=buf.
  - cnt++ at the edge.
  - If cnt+1==len go to FIN, else go to RD.
- FIN:
  - done=1 for exactly one cycle, busy=0, dm_we=0, then go to IDLE.
  - err is valid in this cycle and cleared on return to IDLE.
- Address arithmetic is modulo 2**AW. Regions wrap from 31 to 0 with no error.
- Latency:
  - len=N (N>=1) takes 2N cycles of busy, plus the FIN cycle.
  - done asserts 2N+1 cycles after the start edge.
- Copy order is ascending and forward-only. With overlapping regions where dst is in (src, src+len), source words already overwritten are read back as overwritten. This is the defined behaviour.
- start while busy, or while in FIN, is ignored: no queueing, latched parameters unchanged.
- dm_addr is driven only in RD/WR. In IDLE and FIN it holds 0.

Optional Feature:
- DM_FILL_EN defined:
  - A start with fill_mode=1 latches fill_data.
  - The FSM skips RD and runs WR-only cycles writing fill_data to dst..dst+len-1.
  - Latency is N cycles plus FIN; src is ignored.
- DM_FILL_EN undefined:
  - fill_mode and fill_data ports remain present but are ignored.
  - Every start is a copy; no fill logic is synthesised.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RD, WR, FIN);
  - the AW/DW defaults;
  - the memory depth constant 2**AW.
- The engine is one module. No sub-module is needed; the address adder and counter are trivial.
- The bench instantiates the existing data memory as the responder.

Test Plan:
- Basic copy: preload mem[0..3]=A0..A3, then start src=0 dst=8 len=4. Expect mem[8..11]=A0..A3, done 9 cycles after start, err=0, mem[0..3] unchanged.
- Wrap-around: src=30 dst=2 len=4. Reads hit 30, 31, 0, 1 and writes hit 2, 3, 4, 5. Then src=2 dst=30 len=4 writes 30, 31, 0, 1.
- Zero and illegal length:
  - len=0: done next cycle, err=0, dm_we never high.
  - len=33: done next cycle, err=1, no writes.
- Overlap forward: mem[0..3]=1,2,3,4, then src=0 dst=1 len=3. Expect mem[1..3]=1,1,1.
- Ignored start and reset abort:
  - Pulse start mid-transfer: no change in outcome.
  - Assert rst_n=0 during WR of word 2 of 4: busy, dm_we and done go to 0 immediately, only words 0..1 are written, and the next start works normally.
- DM_FILL_EN: fill_mode=1, fill_data=DEADBEEF, dst=16, len=5. Expect mem[16..20]=DEADBEEF and done 6 cycles after start. In a build without the macro, the same stimulus performs a copy.

Source files
------------

// File: rtl/dm_copy_engine_pkg.sv
// Shared definitions for the data-memory copy engine: default widths,
// memory depth and the engine state encoding.
package dm_copy_engine_pkg;

  localparam int unsigned DM_AW    = 5;
  localparam int unsigned DM_DW    = 32;
  localparam int unsigned DM_DEPTH = 1 << DM_AW;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    FIN
  } dm_state_e;

endpackage

// File: rtl/dm_copy_engine.sv
// Block copy master for the data memory (read word, write word, repeat).
// Optional build macro DM_FILL_EN adds a write-only pattern fill mode.
module dm_copy_engine
  import dm_copy_engine_pkg::*;
#(
  parameter int unsigned AW = DM_AW,
  parameter int unsigned DW = DM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  input  logic          fill_mode,
  input  logic [DW-1:0] fill_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] dm_addr,
  output logic          dm_we,
  output logic [DW-1:0] dm_wd,
  input  logic [DW-1:0] dm_rd
);

  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  dm_state_e     state, state_nxt;
  logic [AW-1:0] src_r, dst_r;
  logic [AW:0]   len_r, cnt, cnt_inc;
  logic [DW-1:0] wbuf;
  logic          err_r;
  logic          len_bad;

  logic          fill_go;
  logic          wr_only;
  logic [DW-1:0] wr_data;

  assign cnt_inc = cnt + CNT_ONE;
  assign len_bad = (len > LEN_MAX);

`ifdef DM_FILL_EN
  logic          fill_r;
  logic [DW-1:0] fill_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_r <= 1'b0;
      fill_d <= '0;
    end else if (state == IDLE && start) begin
      fill_r <= fill_mode;
      fill_d <= fill_data;
    end
  end

  assign fill_go = fill_mode;
  assign wr_only = fill_r;
  assign wr_data = fill_r ? fill_d : wbuf;
`else
  logic unused_fill;
  assign unused_fill = ^{fill_mode, fill_data};
  assign fill_go     = 1'b0;
  assign wr_only     = 1'b0;
  assign wr_data     = wbuf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_wd     = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len == '0 || len_bad) state_nxt = FIN;
          else if (fill_go)         state_nxt = WR;
          else                      state_nxt = RD;
        end
      end
      RD: begin
        busy      = 1'b1;
        dm_addr   = src_r + cnt[AW-1:0];
        state_nxt = WR;
      end
      WR: begin
        busy    = 1'b1;
        dm_we   = 1'b1;
        dm_addr = dst_r + cnt[AW-1:0];
        dm_wd   = wr_data;
        if (cnt_inc == len_r) state_nxt = FIN;
        else if (wr_only)     state_nxt = WR;
        else                  state_nxt = RD;
      end
      FIN: begin
        done      = 1'b1;
        err       = err_r;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are latched even for zero/illegal lengths; only err_r matters then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_r <= '0;
      dst_r <= '0;
      len_r <= '0;
      cnt   <= '0;
      wbuf  <= '0;
      err_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_r <= src;
            dst_r <= dst;
            len_r <= len;
            cnt   <= '0;
            err_r <= len_bad;
          end
        end
        RD:  wbuf  <= dm_rd;
        WR:  cnt   <= cnt_inc;
        FIN: err_r <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_copy_engine.sv
// Scoreboard bench for dm_copy_engine with a behavioural data memory responder.
module tb_dm_copy_engine;
  import dm_copy_engine_pkg::*;

  localparam int  AW    = DM_AW;
  localparam int  DW    = DM_DW;
  localparam int  DEPTH = DM_DEPTH;
  localparam time P     = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] src = '0;
  logic [AW-1:0] dst = '0;
  logic [AW:0]   len = '0;
  logic          fill_mode = 1'b0;
  logic [DW-1:0] fill_data = '0;
  logic          busy, done, err, dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wd, dm_rd;

  logic [DW-1:0] mem [DEPTH];
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_wd = '0;

  logic [DW-1:0] ref_mem [DEPTH];

  typedef struct {
    time                          t0;
    int                           lat;
    logic                         err;
    logic [DEPTH-1:0][DW-1:0]     img;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  dm_copy_engine #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src(src), .dst(dst), .len(len),
    .fill_mode(fill_mode), .fill_data(fill_data), .busy(busy), .done(done),
    .err(err), .dm_addr(dm_addr), .dm_we(dm_we), .dm_wd(dm_wd), .dm_rd(dm_rd)
  );

  always #(P/2) clk = ~clk;

  always @(posedge clk) begin
    if (dm_we)      mem[dm_addr] <= dm_wd;
    else if (pl_we) mem[pl_addr] <= pl_wd;
  end
  assign dm_rd = mem[dm_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each done pulse.
  exp_t mon_e;
  int   mon_lat;
  int   mon_bad;
  always @(negedge clk) begin
    if (rst_n) begin
      if (!busy) begin
        check("idle_we", {31'b0, dm_we}, 32'd0);
        check("idle_addr", {{(32-AW){1'b0}}, dm_addr}, 32'd0);
      end
      if (!done) check("err_without_done", {31'b0, err}, 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no transfer at %0t", $time);
        end else begin
          mon_e   = sb.pop_front();
          mon_lat = int'(($time - mon_e.t0 - P/2) / P) + 1;
          check("latency", mon_lat, mon_e.lat);
          check("err", {31'b0, err}, {31'b0, mon_e.err});
          mon_bad = -1;
          for (int i = 0; i < DEPTH; i++)
            if (mon_bad < 0 && mem[i] !== mon_e.img[i]) mon_bad = i;
          checks++;
          if (mon_bad >= 0) begin
            errors++;
            $display("FAIL mem_image: word %0d got %h expected %h", mon_bad,
                     mem[mon_bad], mon_e.img[mon_bad]);
          end
        end
      end
    end
  end

  task automatic preload(input int a, input logic [DW-1:0] v);
    @(negedge clk);
    pl_we   = 1'b1;
    pl_addr = a[AW-1:0];
    pl_wd   = v;
    @(posedge clk);
    #1 pl_we = 1'b0;
    ref_mem[a] = v;
  endtask

  // Reference: plain ascending word loop over the modular address space.
  task automatic model(input int s, input int d, input int n, input logic fm,
                       input logic [DW-1:0] fd, output int lat, output logic e);
    logic do_fill;
`ifdef DM_FILL_EN
    do_fill = fm;
`else
    do_fill = fm & 1'b0;
`endif
    e = 1'b0;
    if (n == 0) lat = 1;
    else if (n > DEPTH) begin
      lat = 1;
      e   = 1'b1;
    end else if (do_fill) begin
      for (int i = 0; i < n; i++) ref_mem[(d + i) % DEPTH] = fd;
      lat = n + 1;
    end else begin
      for (int i = 0; i < n; i++) ref_mem[(d + i) % DEPTH] = ref_mem[(s + i) % DEPTH];
      lat = 2 * n + 1;
    end
  endtask

  task automatic run(input int s, input int d, input int n, input logic fm,
                     input logic [DW-1:0] fd, input bit poke);
    exp_t e;
    int   lat;
    logic er;
    int   k;
    model(s, d, n, fm, fd, lat, er);
    e.lat = lat;
    e.err = er;
    for (int i = 0; i < DEPTH; i++) e.img[i] = ref_mem[i];
    @(negedge clk);
    src = s[AW-1:0]; dst = d[AW-1:0]; len = n[AW:0];
    fill_mode = fm; fill_data = fd; start = 1'b1;
    @(posedge clk);
    e.t0 = $time;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      repeat (2) @(negedge clk);
      src = AW'($urandom); dst = AW'($urandom);
      len = (AW+1)'($urandom_range(1, DEPTH)); fill_mode = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles (len=%0d)", n);
      sb.delete();
    end
  endtask

  task automatic reset_abort();
    int k;
    for (int i = 0; i < 4; i++) preload(20 + i, $urandom);
    @(negedge clk);
    src = 5'd20; dst = 5'd24; len = 6'd4; fill_mode = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_we", {31'b0, dm_we}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    ref_mem[24] = ref_mem[20];
    ref_mem[25] = ref_mem[21];
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    k = -1;
    for (int i = 0; i < DEPTH; i++) if (k < 0 && mem[i] !== ref_mem[i]) k = i;
    checks++;
    if (k >= 0) begin
      errors++;
      $display("FAIL abort_mem: word %0d got %h expected %h", k, mem[k], ref_mem[k]);
    end
  endtask

  initial begin
    #(P * 50000);
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d, n;
    logic fm;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_we", {31'b0, dm_we}, 32'd0);
    check("rst_addr", {{(32-AW){1'b0}}, dm_addr}, 32'd0);
    check("rst_wd", dm_wd, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) preload(i, $urandom);

    for (int i = 0; i < 4; i++) preload(i, 32'hA0A0_0000 | i);
    run(0, 8, 4, 1'b0, '0, 1'b0);

    for (int i = 0; i < 2; i++) begin
      preload(30 + i, $urandom);
      preload(i, $urandom);
    end
    run(30, 2, 4, 1'b0, '0, 1'b0);
    run(2, 30, 4, 1'b0, '0, 1'b0);

    run(5, 9, 0, 1'b0, '0, 1'b0);
    run(5, 9, 33, 1'b0, '0, 1'b0);

    for (int i = 0; i < 4; i++) preload(i, i + 1);
    run(0, 1, 3, 1'b0, '0, 1'b0);

    run(10, 20, 6, 1'b0, '0, 1'b1);

    reset_abort();
    run(3, 12, 5, 1'b0, '0, 1'b0);

    run(0, 16, 5, 1'b1, 32'hDEAD_BEEF, 1'b0);
    run(4, 9, 32, 1'b0, '0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      s  = $urandom_range(0, DEPTH - 1);
      d  = $urandom_range(0, DEPTH - 1);
      n  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(1, 12);
      fm = 1'($urandom_range(0, 1));
      run(s, d, n, fm, $urandom, (!fm && n >= 2 && n <= DEPTH && t % 3 == 0));
    end

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
